// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status/Cause/EPC registers plus the
// redirect handshake toward the PC unit for exceptions, interrupts and Eret.
module cp0_exc_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        commit,
  input  logic        Break,
  input  logic        Syscall,
  input  logic        Eret,
  input  logic        Reserved_instruction,
  input  logic        Mtc0,
  input  logic        Mfc0,
  input  logic [4:0]  cp0_rd,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_next,
  input  logic [5:0]  irq,
  input  logic        redirect_ack,
  output logic        redirect_req,
  output logic [31:0] redirect_pc,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  localparam logic [31:0] EXC_VECTOR = 32'h0000_F000;
  localparam logic [4:0]  EXC_INT    = 5'd0;
  localparam logic [4:0]  EXC_SYS    = 5'd8;
  localparam logic [4:0]  EXC_BP     = 5'd9;
  localparam logic [4:0]  EXC_RI     = 5'd10;

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ie;
  logic        r_exl;
  logic [5:0]  r_im;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_redirect_pc;

  logic        w_accept;
  logic        w_exc;
  logic        w_int_pend;
  logic        w_take_exc;
  logic        w_take_eret;
  logic        w_take_int;
  logic        w_mtc0_wr;
  logic        w_redirect;
  logic [4:0]  w_exc_code;
  logic        w_unused;

  // Mfc0 needs no qualification: rdata is a pure decode of cp0_rd.
  assign w_unused = Mfc0;

  assign w_accept    = (r_state == S_IDLE) && commit;
  assign w_exc       = Reserved_instruction | Syscall | Break;
  assign w_int_pend  = r_ie & ~r_exl & (|(irq & r_im));
  assign w_take_exc  = w_accept & w_exc;
  assign w_take_eret = w_accept & ~w_exc & Eret;
  assign w_take_int  = w_accept & ~w_exc & ~Eret & w_int_pend;
  // An interrupt boundary still retires the committing Mtc0.
  assign w_mtc0_wr   = w_accept & ~w_exc & ~Eret & Mtc0;
  assign w_redirect  = w_take_exc | w_take_eret | w_take_int;

  always_comb begin
    if (Reserved_instruction) w_exc_code = EXC_RI;
    else if (Syscall)         w_exc_code = EXC_SYS;
    else                      w_exc_code = EXC_BP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_redirect)   w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (redirect_ack) w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    redirect_req = (r_state == S_WAIT_ACK);
  end

  // Later assignments deliberately override the Mtc0 write on an interrupt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ie          <= 1'b0;
      r_exl         <= 1'b0;
      r_im          <= 6'd0;
      r_ip          <= 6'd0;
      r_exccode     <= 5'd0;
      r_epc         <= 32'd0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_ip <= irq;
      if (w_mtc0_wr && cp0_rd == 5'd12) begin
        r_ie  <= wdata[0];
        r_exl <= wdata[1];
        r_im  <= wdata[15:10];
      end
      if (w_mtc0_wr && cp0_rd == 5'd14) r_epc <= wdata;
      if (w_take_exc) begin
        r_epc         <= pc_cur;
        r_exccode     <= w_exc_code;
        r_exl         <= 1'b1;
        r_redirect_pc <= EXC_VECTOR;
      end
      if (w_take_int) begin
        r_epc         <= pc_next;
        r_exccode     <= EXC_INT;
        r_exl         <= 1'b1;
        r_redirect_pc <= EXC_VECTOR;
      end
      if (w_take_eret) begin
        r_exl         <= 1'b0;
        r_redirect_pc <= r_epc;
      end
    end
  end

  assign status      = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign cause       = {16'd0, r_ip, 3'd0, r_exccode, 2'd0};
  assign epc         = r_epc;
  assign redirect_pc = r_redirect_pc;

  always_comb begin
    case (cp0_rd)
      5'd12:   rdata = status;
      5'd13:   rdata = cause;
      5'd14:   rdata = epc;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed vector table, reset-in-handshake sequence,
// then randomized traffic checked against a behavioural model.
module tb_cp0_exc_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit, Break, Syscall, Eret, Reserved_instruction, Mtc0, Mfc0;
  logic [4:0]  cp0_rd;
  logic [31:0] wdata, pc_cur, pc_next;
  logic [5:0]  irq;
  logic        redirect_ack;
  logic        redirect_req;
  logic [31:0] redirect_pc, rdata, status, cause, epc;

  cp0_exc_ctrl dut (
    .clock(clock), .reset(reset), .commit(commit), .Break(Break), .Syscall(Syscall),
    .Eret(Eret), .Reserved_instruction(Reserved_instruction), .Mtc0(Mtc0), .Mfc0(Mfc0),
    .cp0_rd(cp0_rd), .wdata(wdata), .pc_cur(pc_cur), .pc_next(pc_next), .irq(irq),
    .redirect_ack(redirect_ack), .redirect_req(redirect_req), .redirect_pc(redirect_pc),
    .rdata(rdata), .status(status), .cause(cause), .epc(epc)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] F_COMMIT = 7'h01;
  localparam logic [6:0] F_BRK    = 7'h02;
  localparam logic [6:0] F_SYS    = 7'h04;
  localparam logic [6:0] F_ERET   = 7'h08;
  localparam logic [6:0] F_RI     = 7'h10;
  localparam logic [6:0] F_MTC0   = 7'h20;
  localparam logic [6:0] F_ACK    = 7'h40;
  localparam logic [31:0] VEC     = 32'h0000_F000;

  typedef struct {
    logic [6:0]  fl;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pcc;
    logic [31:0] pcn;
    logic [5:0]  irq;
    logic        e_req;
    logic [31:0] e_rpc;
    logic [31:0] e_st;
    logic [31:0] e_ca;
    logic [31:0] e_epc;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[24];
  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state: architectural fields plus "waiting for ack".
  logic        m_ie, m_exl, m_wait;
  logic [5:0]  m_im, m_ip;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_rpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'd0, m_im, 8'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {16'd0, m_ip, 3'd0, m_code, 2'd0};
  endfunction

  task automatic model_reset();
    m_ie = 1'b0; m_exl = 1'b0; m_wait = 1'b0; m_im = '0; m_ip = '0;
    m_code = '0; m_epc = '0; m_rpc = '0;
  endtask

  // Applies one rising edge's worth of architectural rules to the model.
  task automatic model_step();
    logic pend;
    pend = m_ie && !m_exl && ((irq & m_im) != 6'd0);
    if (!m_wait && commit) begin
      if (Reserved_instruction || Syscall || Break) begin
        m_code = Reserved_instruction ? 5'd10 : (Syscall ? 5'd8 : 5'd9);
        m_epc = pc_cur; m_exl = 1'b1; m_rpc = VEC; m_wait = 1'b1;
      end else if (Eret) begin
        m_exl = 1'b0; m_rpc = m_epc; m_wait = 1'b1;
      end else begin
        if (Mtc0 && cp0_rd == 5'd12) begin
          m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:10];
        end
        if (Mtc0 && cp0_rd == 5'd14) m_epc = wdata;
        if (pend) begin
          m_epc = pc_next; m_code = 5'd0; m_exl = 1'b1; m_rpc = VEC; m_wait = 1'b1;
        end
      end
    end else if (m_wait && redirect_ack) begin
      m_wait = 1'b0;
    end
    m_ip = irq;
  endtask

  task automatic clear_inputs();
    commit = 0; Break = 0; Syscall = 0; Eret = 0; Reserved_instruction = 0;
    Mtc0 = 0; Mfc0 = 0; cp0_rd = '0; wdata = '0; pc_cur = '0; pc_next = '0;
    irq = '0; redirect_ack = 0;
  endtask

  initial begin
    vt[0]  = '{7'h00,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, 32'h0,   32'h0,    32'h0,    32'h0,         32'h0};
    vt[1]  = '{F_COMMIT|F_SYS,   5'd0,  32'h0,         32'h100, 32'h104, 6'h00, 1'b1, VEC,     32'h2,    32'h20,   32'h100,       32'h0};
    vt[2]  = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, VEC,     32'h2,    32'h20,   32'h100,       32'h0};
    vt[3]  = '{F_COMMIT|F_MTC0,  5'd12, 32'h0000_0401, 32'h104, 32'h108, 6'h01, 1'b0, VEC,     32'h401,  32'h420,  32'h100,       32'h401};
    vt[4]  = '{F_COMMIT,         5'd0,  32'h0,         32'h200, 32'h204, 6'h01, 1'b1, VEC,     32'h403,  32'h400,  32'h204,       32'h0};
    vt[5]  = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h01, 1'b0, VEC,     32'h403,  32'h400,  32'h204,       32'h0};
    vt[6]  = '{F_COMMIT|F_RI|F_SYS, 5'd0, 32'h0,       32'h300, 32'h304, 6'h00, 1'b1, VEC,     32'h403,  32'h28,   32'h300,       32'h0};
    vt[7]  = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, VEC,     32'h403,  32'h28,   32'h300,       32'h0};
    vt[8]  = '{F_COMMIT|F_ERET,  5'd0,  32'h0,         32'h400, 32'h404, 6'h00, 1'b1, 32'h300, 32'h401,  32'h28,   32'h300,       32'h0};
    vt[9]  = '{7'h00,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b1, 32'h300, 32'h401,  32'h28,   32'h300,       32'h0};
    vt[10] = '{F_COMMIT|F_SYS,   5'd0,  32'h0,         32'h500, 32'h504, 6'h00, 1'b1, 32'h300, 32'h401,  32'h28,   32'h300,       32'h0};
    vt[11] = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, 32'h300, 32'h401,  32'h28,   32'h300,       32'h0};
    vt[12] = '{F_COMMIT|F_MTC0,  5'd12, 32'h0000_0403, 32'h0,   32'h0,   6'h00, 1'b0, 32'h300, 32'h403,  32'h28,   32'h300,       32'h403};
    vt[13] = '{F_COMMIT,         5'd13, 32'h0,         32'h600, 32'h604, 6'h21, 1'b0, 32'h300, 32'h403,  32'h8428, 32'h300,       32'h8428};
    vt[14] = '{F_COMMIT|F_MTC0,  5'd14, 32'h1234_5678, 32'h0,   32'h0,   6'h00, 1'b0, 32'h300, 32'h403,  32'h28,   32'h1234_5678, 32'h1234_5678};
    vt[15] = '{F_COMMIT|F_MTC0,  5'd13, 32'hFFFF_FFFF, 32'h0,   32'h0,   6'h00, 1'b0, 32'h300, 32'h403,  32'h28,   32'h1234_5678, 32'h28};
    vt[16] = '{F_ACK,            5'd12, 32'h0,         32'h0,   32'h0,   6'h00, 1'b0, 32'h300, 32'h403,  32'h28,   32'h1234_5678, 32'h403};
    vt[17] = '{F_COMMIT|F_MTC0,  5'd12, 32'hFFFF_FFFF, 32'h0,   32'h0,   6'h00, 1'b0, 32'h300, 32'hFC03, 32'h28,   32'h1234_5678, 32'hFC03};
    vt[18] = '{F_COMMIT|F_BRK,   5'd0,  32'h0,         32'h700, 32'h704, 6'h00, 1'b1, VEC,     32'hFC03, 32'h24,   32'h700,       32'h0};
    vt[19] = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, VEC,     32'hFC03, 32'h24,   32'h700,       32'h0};
    vt[20] = '{F_COMMIT|F_ERET,  5'd0,  32'h0,         32'h800, 32'h804, 6'h00, 1'b1, 32'h700, 32'hFC01, 32'h24,   32'h700,       32'h0};
    vt[21] = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, 32'h700, 32'hFC01, 32'h24,   32'h700,       32'h0};
    vt[22] = '{F_COMMIT|F_MTC0,  5'd14, 32'hAAAA_0000, 32'h900, 32'h904, 6'h02, 1'b1, VEC,     32'hFC03, 32'h800,  32'h904,       32'h904};
    vt[23] = '{F_ACK,            5'd0,  32'h0,         32'h0,   32'h0,   6'h00, 1'b0, VEC,     32'hFC03, 32'h0,    32'h904,       32'h0};

    clear_inputs();
    reset = 1'b1;
    cp0_rd = 5'd12;
    repeat (2) @(negedge clock);
    chk("reset_req",    {31'd0, redirect_req}, 32'd0);
    chk("reset_rpc",    redirect_pc, 32'd0);
    chk("reset_status", status, 32'd0);
    chk("reset_cause",  cause, 32'd0);
    chk("reset_epc",    epc, 32'd0);
    chk("reset_rdata",  rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      commit = vt[i].fl[0]; Break = vt[i].fl[1]; Syscall = vt[i].fl[2];
      Eret = vt[i].fl[3]; Reserved_instruction = vt[i].fl[4]; Mtc0 = vt[i].fl[5];
      redirect_ack = vt[i].fl[6]; Mfc0 = (vt[i].rd != 5'd0);
      cp0_rd = vt[i].rd; wdata = vt[i].wd; pc_cur = vt[i].pcc; pc_next = vt[i].pcn;
      irq = vt[i].irq;
      @(negedge clock);
      chk($sformatf("vec%0d_req", i),    {31'd0, redirect_req}, {31'd0, vt[i].e_req});
      chk($sformatf("vec%0d_rpc", i),    redirect_pc, vt[i].e_rpc);
      chk($sformatf("vec%0d_status", i), status, vt[i].e_st);
      chk($sformatf("vec%0d_cause", i),  cause, vt[i].e_ca);
      chk($sformatf("vec%0d_epc", i),    epc, vt[i].e_epc);
      chk($sformatf("vec%0d_rdata", i),  rdata, vt[i].e_rd);
    end

    // Reset arriving while a redirect is waiting for its acknowledge.
    clear_inputs();
    commit = 1; Syscall = 1; pc_cur = 32'h100; irq = 6'h3F;
    @(negedge clock);
    chk("midhs_req_before", {31'd0, redirect_req}, 32'd1);
    clear_inputs();
    irq = 6'h3F;
    #2 reset = 1'b1;
    #1;
    chk("midhs_req",    {31'd0, redirect_req}, 32'd0);
    chk("midhs_rpc",    redirect_pc, 32'd0);
    chk("midhs_status", status, 32'd0);
    chk("midhs_cause",  cause, 32'd0);
    chk("midhs_epc",    epc, 32'd0);
    @(negedge clock);
    chk("midhs_cause_held", cause, 32'd0);
    clear_inputs();
    reset = 1'b0;
    model_reset();

    for (int c = 0; c < 800; c++) begin
      commit = ($urandom_range(0, 2) == 0);
      Reserved_instruction = ($urandom_range(0, 9) == 0);
      Syscall = ($urandom_range(0, 9) == 0);
      Break = ($urandom_range(0, 9) == 0);
      Eret = ($urandom_range(0, 6) == 0);
      Mtc0 = ($urandom_range(0, 2) == 0);
      Mfc0 = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0: cp0_rd = 5'd12;
        1: cp0_rd = 5'd13;
        2: cp0_rd = 5'd14;
        default: cp0_rd = 5'($urandom);
      endcase
      wdata = $urandom;
      pc_cur = {$urandom, 2'b00} & 32'h0000_FFFC;
      pc_next = pc_cur + 32'd4;
      irq = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
      redirect_ack = ($urandom_range(0, 2) == 0);
      model_step();
      @(negedge clock);
      chk("rnd_req",    {31'd0, redirect_req}, {31'd0, m_wait});
      chk("rnd_rpc",    redirect_pc, m_rpc);
      chk("rnd_status", status, m_status());
      chk("rnd_cause",  cause, m_cause());
      chk("rnd_epc",    epc, m_epc);
      case (cp0_rd)
        5'd12:   chk("rnd_rdata", rdata, m_status());
        5'd13:   chk("rnd_rdata", rdata, m_cause());
        5'd14:   chk("rnd_rdata", rdata, m_epc);
        default: chk("rnd_rdata", rdata, 32'd0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port commit  input  1  one-cycle pulse marking the instruction boundary (last cycle of the current instruction).
REQ-004 SHALL have ports Break, Syscall, Eret, Reserved_instruction, Mtc0, Mfc0  input  1 each  decoded instruction flags from the control unit, valid while commit=1.
REQ-005 SHALL have port cp0_rd  input  5  CP0 register number (Instruction[15:11]).
REQ-006 SHALL have port wdata  input  32  rt value for Mtc0.
REQ-007 SHALL have ports pc_cur, pc_next  input  32 each  address of the committing instruction and its sequential successor.
REQ-008 SHALL have port irq  input  6  level-sensitive external interrupt lines.
REQ-009 SHALL have port redirect_ack  input  1  PC unit has loaded redirect_pc.
REQ-010 SHALL have port redirect_req  output  1  request to load redirect_pc into PC.
REQ-011 SHALL have port redirect_pc  output  32  handler vector or return address.
REQ-012 SHALL have port rdata  output  32  Mfc0 read data.
REQ-013 SHALL have ports status, cause, epc  output  32 each  architectural register contents.

Function
REQ-014 SHALL implement Status (reg 12): bit0 IE, bit1 EXL, bits[15:10] IM; other bits read 0.
REQ-015 SHALL implement Cause (reg 13): bits[6:2] ExcCode, bits[15:10] IP; other bits read 0; not software-writable.
REQ-016 SHALL implement EPC (reg 14), 32 bits.
REQ-017 SHALL register IP <= irq every cycle, independent of FSM state.
REQ-018 SHALL drive rdata combinationally: cp0_rd 12/13/14 gives the corresponding register, any other value gives 0.
REQ-019 SHALL implement FSM with states IDLE and WAIT_ACK.
REQ-020 SHALL, in IDLE with commit=1, evaluate in fixed priority: Reserved_instruction (ExcCode 10), Syscall (8), Break (9), Eret, pending interrupt (ExcCode 0), Mtc0.
REQ-021 SHALL define pending interrupt as IE=1 and EXL=0 and (irq & IM) != 0, evaluated on pre-commit Status.
REQ-022 SHALL, on a taken exception, set EPC <= pc_cur, set ExcCode, set EXL <= 1, set redirect_pc <= 32'h0000_F000, assert redirect_req, and enter WAIT_ACK on the next edge.
REQ-023 SHALL, on a taken interrupt, do the same as REQ-022 but with EPC <= pc_next and ExcCode 0; the committing Mtc0 (if any) SHALL still take effect.
REQ-024 SHALL, on Eret, set EXL <= 0, set redirect_pc <= EPC, assert redirect_req, and enter WAIT_ACK.
REQ-025 SHALL, on Mtc0 with no exception, write wdata to Status (masked per REQ-014) for reg 12 or to EPC for reg 14; writes to other numbers SHALL be ignored.
REQ-026 SHALL hold redirect_req and redirect_pc stable in WAIT_ACK until redirect_ack=1, then deassert redirect_req on that edge and return to IDLE.
REQ-027 SHALL ignore commit pulses received in WAIT_ACK; no register update and no new request.
REQ-028 SHALL give a latency of one edge from commit to redirect_req=1.
REQ-029 SHALL ignore redirect_ack while in IDLE.

Reset
REQ-030 SHALL, on reset, clear status, cause, epc, and redirect_pc to 0, set redirect_req to 0 and FSM to IDLE, including when reset occurs mid-handshake.

Verification
REQ-031 SHALL check: Syscall+commit, pc_cur=0x100 -> next edge redirect_req=1, redirect_pc=0xF000, epc=0x100, ExcCode=8, EXL=1.
REQ-032 SHALL check: Mtc0 reg12 wdata=0x0000_0401, irq[0]=1, then commit with pc_next=0x204 -> interrupt taken, epc=0x204, ExcCode=0.
REQ-033 SHALL check: Reserved_instruction and Syscall both set at commit -> ExcCode=10.
REQ-034 SHALL check: epc=0x300, Eret+commit -> redirect_pc=0x300, EXL=0; redirect_req held for 3 cycles until redirect_ack, and a commit during the wait is ignored.
REQ-035 SHALL check: EXL=1 with irq active -> no interrupt taken; Mfc0 cp0_rd=13 returns IP=irq in bits[15:10].
REQ-036 SHALL check: reset asserted in WAIT_ACK -> redirect_req=0 and all registers 0 immediately.
